multicycle_controller: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback over several cycles, driving the datapath enables, the mux selects and the 2-bit aluop. The aluop feeds the existing ALU decoder, which turns it into alucontrol. Adds a memory wait handshake and a sticky illegal-opcode flag.

---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/mc_output_decode.sv | 76 +++++++
 rtl/multicycle_controller.sv | 111 +++++++++++
 tb/tb_multicycle_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// datapath select encodings and the control word driven by the output decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // pcwrite and branch stay internal; the top folds them into pcen.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] opcode);
    logic legal;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational map from FSM state to the datapath control word.
// ready gates the FETCH instruction-register and PC updates.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       ready,
  output ctrl_t      ctrl
);

  // State-to-control-word table; unlisted fields and unreachable states stay zero.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALURES;
        ctrl.irwrite = ready;
        ctrl.pcwrite = ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state
// logic with memory wait handshake, sticky illegal-opcode flag and pcen.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state_r;
  state_t state_nxt_s;
  state_t dec_state_s;
  logic   illegal_r;
  logic   illegal_nxt_s;
  logic   ready_s;
  ctrl_t  ctrl_s;

  // While reset is held the decoder sees FETCH with the access not ready,
  // so no write strobe or PC/IR update can escape from a stale state.
  assign ready_s     = reset & (~MEM_WAIT_EN | mem_ready);
  assign dec_state_s = reset ? state_r : S_FETCH;

  mc_output_decode u_decode (
    .state (dec_state_s),
    .ready (ready_s),
    .ctrl  (ctrl_s)
  );

  // Next-state selection, including wait-state holds and opcode dispatch.
  always_comb begin
    state_nxt_s = S_FETCH;
    case (state_r)
      S_FETCH:    state_nxt_s = ready_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt_s = S_MEMADR;
          OP_RTYPE:     state_nxt_s = S_EXECUTE;
          OP_BEQ:       state_nxt_s = S_BRANCH;
          OP_ADDI:      state_nxt_s = S_ADDIEXEC;
          OP_J:         state_nxt_s = S_JUMP;
          default:      state_nxt_s = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt_s = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_nxt_s = ready_s ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_nxt_s = S_FETCH;
      S_MEMWR:    state_nxt_s = ready_s ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_nxt_s = S_ALUWB;
      S_ALUWB:    state_nxt_s = S_FETCH;
      S_BRANCH:   state_nxt_s = S_FETCH;
      S_ADDIEXEC: state_nxt_s = S_ADDIWB;
      S_ADDIWB:   state_nxt_s = S_FETCH;
      S_JUMP:     state_nxt_s = S_FETCH;
      default:    state_nxt_s = S_FETCH;
    endcase
  end

  // Sticky flag: set when DECODE sees an unsupported opcode.
  always_comb begin
    illegal_nxt_s = illegal_r;
    if ((state_r == S_DECODE) && !op_is_legal(op)) begin
      illegal_nxt_s = 1'b1;
    end else begin
      illegal_nxt_s = illegal_r;
    end
  end

  // State and illegal-flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      illegal_r <= illegal_nxt_s;
    end
  end

  assign iord      = ctrl_s.iord;
  assign memwrite  = ctrl_s.memwrite;
  assign irwrite   = ctrl_s.irwrite;
  assign regdst    = ctrl_s.regdst;
  assign memtoreg  = ctrl_s.memtoreg;
  assign regwrite  = ctrl_s.regwrite;
  assign alusrca   = ctrl_s.alusrca;
  assign alusrcb   = ctrl_s.alusrcb;
  assign pcsrc     = ctrl_s.pcsrc;
  assign aluop     = ctrl_s.aluop;
  assign pcen      = ctrl_s.pcwrite | (ctrl_s.branch & zero);
  assign illegal   = illegal_r;
  assign state_dbg = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: each instruction is
// expanded into its expected state walk, with wait states inserted on the fly.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state_dbg;

  logic       nw_iord, nw_memwrite, nw_irwrite, nw_regdst, nw_memtoreg, nw_regwrite;
  logic       nw_alusrca, nw_pcen, nw_illegal;
  logic [1:0] nw_alusrcb, nw_pcsrc, nw_aluop;
  logic [3:0] nw_state_dbg;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit exp_illegal = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen), .illegal(illegal), .state_dbg(state_dbg)
  );

  multicycle_controller #(.MEM_WAIT_EN(1'b0)) dut_nw (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(nw_iord), .memwrite(nw_memwrite), .irwrite(nw_irwrite), .regdst(nw_regdst),
    .memtoreg(nw_memtoreg), .regwrite(nw_regwrite), .alusrca(nw_alusrca),
    .alusrcb(nw_alusrcb), .pcsrc(nw_pcsrc), .aluop(nw_aluop), .pcen(nw_pcen),
    .illegal(nw_illegal), .state_dbg(nw_state_dbg)
  );

  function automatic logic [13:0] observed();
    return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, pcsrc, aluop, pcen};
  endfunction

  // Expected control word per state, written straight from the state table.
  function automatic logic [13:0] exp_word(input int st, input logic rdy, input logic z);
    logic       e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_pcen;
    logic [1:0] e_sb, e_pcs, e_aop;
    {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_pcen} = 8'd0;
    {e_sb, e_pcs, e_aop} = 6'd0;
    case (st)
      0:  begin e_sb = 2'b01; e_ir = rdy; e_pcen = rdy; end
      1:  e_sb = 2'b11;
      2:  begin e_sa = 1'b1; e_sb = 2'b10; end
      3:  e_iord = 1'b1;
      4:  begin e_m2r = 1'b1; e_rw = 1'b1; end
      5:  begin e_iord = 1'b1; e_mw = 1'b1; end
      6:  begin e_sa = 1'b1; e_aop = 2'b10; end
      7:  begin e_rd = 1'b1; e_rw = 1'b1; end
      8:  begin e_sa = 1'b1; e_aop = 2'b01; e_pcs = 2'b01; e_pcen = z; end
      9:  begin e_sa = 1'b1; e_sb = 2'b10; end
      10: e_rw = 1'b1;
      11: begin e_pcs = 2'b10; e_pcen = 1'b1; end
      default: e_sb = 2'b00;
    endcase
    return {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_sb, e_pcs, e_aop, e_pcen};
  endfunction

  function automatic bit legal_op(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_illegal = 1'b0;
  endtask

  // Walks one instruction cycle by cycle; called at a negedge, returns at one
  // (or, with stop_at hit, right after checking that state, before its edge).
  task automatic run_instr(input logic [5:0] opc, input logic zv, input bit rnd_ready,
                           input int stall_state, input int stall_n, input int stop_at,
                           output int cycles, output int mw_cycles, output int rw_cycles);
    int  plan[$];
    int  idx;
    int  cur;
    int  stalls;
    bit  memst;
    logic rdy;
    plan = {0, 1};
    case (opc)
      6'b100011: plan = {0, 1, 2, 3, 4};
      6'b101011: plan = {0, 1, 2, 5};
      6'b000000: plan = {0, 1, 6, 7};
      6'b000100: plan = {0, 1, 8};
      6'b001000: plan = {0, 1, 9, 10};
      6'b000010: plan = {0, 1, 11};
      default:   plan = {0, 1};
    endcase
    idx = 0; stalls = stall_n; cycles = 0; mw_cycles = 0; rw_cycles = 0;
    op = opc;
    while (idx < plan.size()) begin
      cur = plan[idx];
      memst = (cur == 0) || (cur == 3) || (cur == 5);
      if (memst && cur == stall_state && stalls > 0) begin
        rdy = 1'b0;
        stalls--;
      end else if (memst && !rnd_ready) begin
        rdy = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      mem_ready = rdy;
      zero = (cur == 8) ? zv : 1'($urandom_range(0, 1));
      #1;
      total_cnt++;
      if (state_dbg !== 4'(cur))
        $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", opc, cycles, state_dbg, cur);
      else pass_cnt++;
      total_cnt++;
      if (observed() !== exp_word(cur, rdy, zero))
        $display("FAIL ctrl op=%b state=%0d got=%b want=%b", opc, cur, observed(), exp_word(cur, rdy, zero));
      else pass_cnt++;
      total_cnt++;
      if (illegal !== exp_illegal)
        $display("FAIL illegal state=%0d got=%b want=%b", cur, illegal, exp_illegal);
      else pass_cnt++;
      if (memwrite) mw_cycles++;
      if (regwrite) rw_cycles++;
      cycles++;
      if (cur == stop_at) break;
      if (cycles > 100) begin
        total_cnt++;
        $display("FAIL timeout op=%b got=%0d cycles want<=100", opc, cycles);
        break;
      end
      @(posedge clk);
      if (cur == 1 && !legal_op(opc)) exp_illegal = 1'b1;
      if (!(memst && !rdy)) idx++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b1;
    op = 6'b000010;
    @(negedge clk);
    #1;
    total_cnt++;
    if (state_dbg !== 4'd0) $display("FAIL reset_state got=%0d want=0", state_dbg);
    else pass_cnt++;
    total_cnt++;
    if (illegal !== 1'b0) $display("FAIL reset_illegal got=%b want=0", illegal);
    else pass_cnt++;
    total_cnt++;
    if (observed() !== exp_word(0, 1'b0, 1'b0))
      $display("FAIL reset_ctrl got=%b want=%b", observed(), exp_word(0, 1'b0, 1'b0));
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    exp_illegal = 1'b0;
  endtask

  task automatic test_latency();
    logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    int         lat[6] = '{5, 4, 4, 4, 3, 3};
    int cyc, mw, rw;
    for (int i = 0; i < 6; i++) begin
      run_instr(ops[i], 1'b1, 1'b0, -1, 0, -1, cyc, mw, rw);
      total_cnt++;
      if (cyc !== lat[i]) $display("FAIL latency op=%b got=%0d want=%0d", ops[i], cyc, lat[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sw_wait();
    int cyc, mw, rw;
    run_instr(6'b101011, 1'b0, 1'b0, 5, 2, -1, cyc, mw, rw);
    total_cnt++;
    if (mw !== 3) $display("FAIL sw_memwrite_cycles got=%0d want=3", mw);
    else pass_cnt++;
    total_cnt++;
    if (rw !== 0) $display("FAIL sw_regwrite_cycles got=%0d want=0", rw);
    else pass_cnt++;
    total_cnt++;
    if (cyc !== 6) $display("FAIL sw_wait_latency got=%0d want=6", cyc);
    else pass_cnt++;
  endtask

  task automatic test_beq();
    int cyc, mw, rw;
    run_instr(6'b000100, 1'b1, 1'b0, -1, 0, -1, cyc, mw, rw);
    run_instr(6'b000100, 1'b0, 1'b0, -1, 0, -1, cyc, mw, rw);
    run_instr(6'b100011, 1'b0, 1'b0, 0, 3, -1, cyc, mw, rw);
    total_cnt++;
    if (cyc !== 8) $display("FAIL lw_fetch_wait_latency got=%0d want=8", cyc);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    int cyc, mw, rw;
    run_instr(6'b111111, 1'b0, 1'b0, -1, 0, -1, cyc, mw, rw);
    total_cnt++;
    if (cyc !== 2) $display("FAIL illegal_latency got=%0d want=2", cyc);
    else pass_cnt++;
    run_instr(6'b100011, 1'b0, 1'b1, -1, 0, -1, cyc, mw, rw);
    total_cnt++;
    if (illegal !== 1'b1) $display("FAIL illegal_sticky got=%b want=1", illegal);
    else pass_cnt++;
    apply_reset();
    #1;
    total_cnt++;
    if (illegal !== 1'b0) $display("FAIL illegal_clear got=%b want=0", illegal);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int cyc, mw, rw;
    int stops[2] = '{5, 4};
    logic [5:0] sops[2] = '{6'b101011, 6'b100011};
    for (int i = 0; i < 2; i++) begin
      run_instr(sops[i], 1'b0, 1'b0, 5, 2, stops[i], cyc, mw, rw);
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      total_cnt++;
      if (memwrite !== 1'b0 || regwrite !== 1'b0)
        $display("FAIL midreset_hold st=%0d got=%b%b want=00", stops[i], memwrite, regwrite);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (state_dbg !== 4'd0) $display("FAIL midreset_state st=%0d got=%0d want=0", stops[i], state_dbg);
      else pass_cnt++;
      total_cnt++;
      if (memwrite !== 1'b0 || regwrite !== 1'b0 || pcen !== 1'b0)
        $display("FAIL midreset_strobes st=%0d got=%b%b%b want=000", stops[i], memwrite, regwrite, pcen);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      exp_illegal = 1'b0;
    end
  endtask

  task automatic test_random();
    int cyc, mw, rw;
    logic [5:0] opc;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: opc = 6'b000000;
        1: opc = 6'b100011;
        2: opc = 6'b101011;
        3: opc = 6'b000100;
        4: opc = 6'b001000;
        5: opc = 6'b000010;
        6: opc = 6'($urandom_range(0, 63));
        default: opc = 6'b100011;
      endcase
      run_instr(opc, 1'($urandom_range(0, 1)), 1'b1, -1, 0, -1, cyc, mw, rw);
    end
  endtask

  task automatic test_no_wait();
    int want[6] = '{0, 1, 2, 3, 4, 0};
    apply_reset();
    op = 6'b100011;
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'b0;
      #1;
      total_cnt++;
      if (nw_state_dbg !== 4'(want[c]))
        $display("FAIL nowait_state cyc=%0d got=%0d want=%0d", c, nw_state_dbg, want[c]);
      else pass_cnt++;
      if (c == 0) begin
        total_cnt++;
        if (nw_irwrite !== 1'b1 || nw_pcen !== 1'b1)
          $display("FAIL nowait_fetch got=%b%b want=11", nw_irwrite, nw_pcen);
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_mid_reset();
    test_random();
    test_no_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
